// File: rtl/if_id_queue_pkg.sv
// Shared widths, constants and the queued entry layout for the fetch-to-decode queue.
package if_id_queue_pkg;

  localparam int INST_ADDR_W    = 32;
  localparam int INST_W         = 32;
  localparam int IF_QUEUE_DEPTH = 2;
  localparam int ENTRY_W        = INST_ADDR_W + INST_W;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle for the instruction queue.
// Handshake: a pair moves when valid and ready are both high at a posedge; ready never waits on valid.
interface if_id_queue_if #(
  parameter int PTR_W = 1
);
  import if_id_queue_pkg::*;

  logic                   flush;
  logic [INST_ADDR_W-1:0] if_pc;
  logic [INST_W-1:0]      if_inst;
  logic                   if_valid;
  logic                   if_ready;
  logic [INST_ADDR_W-1:0] id_pc;
  logic [INST_W-1:0]      id_inst;
  logic                   id_valid;
  logic                   id_ready;
  logic [PTR_W:0]         count;

  modport master (
    output flush, if_pc, if_inst, if_valid, id_ready,
    input  if_ready, id_pc, id_inst, id_valid, count
  );

  modport slave (
    input  flush, if_pc, if_inst, if_valid, id_ready,
    output if_ready, id_pc, id_inst, id_valid, count
  );

endinterface

// File: rtl/if_id_queue_inst_queue_mem.sv
// DEPTH x 64-bit entry storage: one synchronous write port, one asynchronous read port, not reset.
module inst_queue_mem #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1,
  parameter int W     = 64
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction FIFO: pointers, occupancy, flush priority and head output muxing.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IF_QUEUE_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave bus
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic             not_full;
  logic [ENTRY_W-1:0] rdata;
  entry_t           head;
  entry_t           wentry;

  // Both flags come from registered count only, so ready never loops back through decode.
  assign not_empty = (count != '0);
  assign not_full  = (count != FULL_COUNT);
  assign push      = bus.if_valid & not_full;
  assign pop       = not_empty & bus.id_ready;

  assign wentry.pc   = bus.if_pc;
  assign wentry.inst = bus.if_inst;

  inst_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~bus.flush),
    .waddr (wr_ptr),
    .wdata (wentry),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign head = entry_t'(rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An empty queue presents zero words so decode sees a nop.
  assign bus.id_valid = not_empty;
  assign bus.id_pc    = not_empty ? head.pc   : ZERO_WORD;
  assign bus.id_inst  = not_empty ? head.inst : ZERO_WORD;
  assign bus.if_ready = not_full;
  assign bus.count    = count;

endmodule
